// File: rtl/cursor_input_ctrl.sv
// Cursor/placement front end for the 3x3 TicTacToe board: turns debounced button
// levels into wrapped cursor moves with auto-repeat and a valid/ready placement request.
module cursor_input_ctrl #(
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       enable,
  input  logic       place_ready,
  output logic [1:0] cursor_row,
  output logic [1:0] cursor_col,
  output logic [3:0] cursor_idx,
  output logic       place_valid,
  output logic [3:0] place_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  // Bit order shared by level, previous-level and step vectors:
  // [0]=up [1]=down [2]=left [3]=right [4]=sel
  logic [4:0] btn_lvl;
  logic [4:0] prev_q;
  logic [4:0] press;
  logic [3:0] dir_lvl;

  assign btn_lvl = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign press   = btn_lvl & ~prev_q;
  assign dir_lvl = btn_lvl[3:0];

  rep_state_e state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  held_q, held_d;
  logic [23:0] cnt_limit;
  logic        held_same;
  logic [3:0]  rep_step;

  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [3:0] idx_q, idx_d;
  logic       pvalid_q, pvalid_d;
  logic [3:0] pidx_q, pidx_d;
  logic [3:0] step;

  function automatic logic [1:0] wrap_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign cnt_limit = (state_q == ST_DELAY) ? REPEAT_DELAY : REPEAT_RATE;
  assign held_same = (dir_lvl == held_q);

  // Repeat FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  // Repeat FSM: next state. Counter is reloaded to 1 on each step so it
  // never exceeds the active limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    unique case (state_q)
      ST_IDLE: begin
        if ($onehot(dir_lvl)) begin
          state_d = ST_DELAY;
          cnt_d   = 24'd1;
          held_d  = dir_lvl;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!held_same) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          held_d  = '0;
        end else if (cnt_q == cnt_limit) begin
          state_d = ST_REPEAT;
          cnt_d   = 24'd1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        held_d  = '0;
      end
    endcase
  end

  // Repeat FSM: outputs
  always_comb begin
    rep_step = '0;
    if ((state_q != ST_IDLE) && held_same && (cnt_q == cnt_limit)) begin
      rep_step = held_q;
    end
  end

  // Cursor datapath: opposite steps cancel, orthogonal steps combine.
  always_comb begin
    step  = press[3:0] | rep_step;
    row_d = row_q;
    col_d = col_q;
    if (step[0] && !step[1]) row_d = wrap_dec(row_q);
    if (step[1] && !step[0]) row_d = wrap_inc(row_q);
    if (step[2] && !step[3]) col_d = wrap_dec(col_q);
    if (step[3] && !step[2]) col_d = wrap_inc(col_q);
    idx_d = {2'b00, row_d} + {1'b0, row_d, 1'b0} + {2'b00, col_d};
  end

  // Placement handshake: a completing transfer blocks acceptance on the same edge.
  always_comb begin
    pvalid_d = pvalid_q;
    pidx_d   = pidx_q;
    if (pvalid_q) begin
      if (place_ready) pvalid_d = 1'b0;
    end else if (press[4] && enable) begin
      pvalid_d = 1'b1;
      pidx_d   = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= btn_lvl;
      row_q    <= 2'd1;
      col_q    <= 2'd1;
      idx_q    <= 4'd4;
      pvalid_q <= 1'b0;
      pidx_q   <= '0;
    end else begin
      prev_q   <= btn_lvl;
      row_q    <= row_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      pvalid_q <= pvalid_d;
      pidx_q   <= pidx_d;
    end
  end

  assign cursor_row  = row_q;
  assign cursor_col  = col_q;
  assign cursor_idx  = idx_q;
  assign place_valid = pvalid_q;
  assign place_idx   = pidx_q;

  a_cursor_range: assert property (@(posedge clk)
    !rst_n || (row_q <= 2'd2 && col_q <= 2'd2 && idx_q <= 4'd8));

  a_idx_consistent: assert property (@(posedge clk)
    !rst_n || (idx_q == {2'b00, row_q} + {1'b0, row_q, 1'b0} + {2'b00, col_q}));

  a_place_idx_stable: assert property (@(posedge clk)
    (rst_n && pvalid_q && !place_ready) |=> (!rst_n || $stable(pidx_q)));

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Bench for cursor_input_ctrl: directed scenarios plus randomized button traffic,
// checked every cycle against a behavioural cursor/repeat/placement model.
module tb_cursor_input_ctrl;

  localparam int D = 10;
  localparam int R = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic       enable;
  logic       place_ready;
  logic [1:0] cursor_row;
  logic [1:0] cursor_col;
  logic [3:0] cursor_idx;
  logic       place_valid;
  logic [3:0] place_idx;

  int total;
  int bad;

  // Model state
  int       m_row, m_col, m_valid, m_pidx;
  bit [4:0] m_prev;
  int       m_edge;
  int       m_arm_at;
  bit [3:0] m_arm_set;

  cursor_input_ctrl #(
    .REPEAT_DELAY(24'd10),
    .REPEAT_RATE (24'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_sel    (btn_sel),
    .enable     (enable),
    .place_ready(place_ready),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .cursor_idx (cursor_idx),
    .place_valid(place_valid),
    .place_idx  (place_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [4:0] cur_btn();
    return {btn_sel, btn_right, btn_left, btn_down, btn_up};
  endfunction

  task automatic set_btn(input bit [4:0] b);
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  // One clock edge of the reference behaviour, using the inputs sampled at that edge.
  task automatic model_edge();
    bit [4:0] b, press;
    bit [3:0] dir, rep, st;
    int age, pre_idx, dv, dh;
    b = cur_btn();
    m_edge++;
    if (!rst_n) begin
      m_row = 1; m_col = 1; m_valid = 0; m_pidx = 0;
      m_prev = b; m_arm_at = -1; m_arm_set = '0;
      return;
    end
    press = b & ~m_prev;
    dir   = b[3:0];
    rep   = '0;
    if (m_arm_at >= 0 && dir != m_arm_set) begin
      m_arm_at = -1;
    end else if (m_arm_at >= 0) begin
      age = m_edge - m_arm_at;
      if (age == D || (age > D && (age - D) % R == 0)) rep = m_arm_set;
    end else if ($countones(dir) == 1) begin
      m_arm_at  = m_edge;
      m_arm_set = dir;
    end
    st      = press[3:0] | rep;
    pre_idx = m_row * 3 + m_col;
    dv      = int'(st[1]) - int'(st[0]);
    dh      = int'(st[3]) - int'(st[2]);
    m_row   = (m_row + dv + 3) % 3;
    m_col   = (m_col + dh + 3) % 3;
    if (m_valid == 1 && place_ready) m_valid = 0;
    else if (m_valid == 0 && press[4] && enable) begin
      m_valid = 1;
      m_pidx  = pre_idx;
    end
    m_prev = b;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("row",   int'(cursor_row),  m_row);
      chk("col",   int'(cursor_col),  m_col);
      chk("idx",   int'(cursor_idx),  m_row * 3 + m_col);
      chk("valid", int'(place_valid), m_valid);
      chk("pidx",  int'(place_idx),   m_pidx);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_edge = 0; m_arm_at = -1; m_arm_set = '0;
    m_row = 0; m_col = 0; m_valid = 0; m_pidx = 0; m_prev = '0;
    rst_n = 1'b0; enable = 1'b1; place_ready = 1'b0;
    set_btn(5'b00000);

    // Right held through reset: no press afterwards
    btn_right = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("held_thru_reset_idx", int'(cursor_idx), 4);
    btn_right = 1'b0;
    tick(1);
    btn_right = 1'b1;
    tick(1);
    chk("repress_right_idx", int'(cursor_idx), 5);
    btn_right = 1'b0;
    tick(2);

    // Up twice with wrap, then diagonal left+down
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(4);
    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(4);
    chk("up_wrap_idx", int'(cursor_idx), 7);
    btn_left = 1'b1; btn_down = 1'b1; tick(1);
    chk("diag_idx", int'(cursor_idx), 0);
    btn_left = 1'b0; btn_down = 1'b0; tick(2);

    // Auto-repeat on right, then a second direction stops it
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    btn_right = 1'b1; tick(31);
    chk("repeat_col", int'(cursor_col), 2);
    btn_right = 1'b0; tick(10);
    chk("release_col", int'(cursor_col), 2);
    btn_right = 1'b1; tick(12);
    btn_up = 1'b1; tick(20);
    chk("two_dir_idx", int'(cursor_idx), 1);
    btn_right = 1'b0; btn_up = 1'b0; tick(2);

    // Placement handshake
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    enable = 1'b1; place_ready = 1'b0;
    btn_sel = 1'b1; tick(5); btn_sel = 1'b0; tick(1);
    btn_right = 1'b1; btn_sel = 1'b1; tick(1);
    btn_right = 1'b0; btn_sel = 1'b0; tick(1);
    chk("held_pidx", int'(place_idx), 4);
    chk("moved_idx", int'(cursor_idx), 5);
    place_ready = 1'b1; tick(1); place_ready = 1'b0;
    chk("ready_clears", int'(place_valid), 0);
    btn_sel = 1'b1; tick(1); btn_sel = 1'b0;
    chk("second_pidx", int'(place_idx), 5);
    tick(1);
    place_ready = 1'b1; tick(1); place_ready = 1'b0;

    // Select ignored when disabled, moves still work
    enable = 1'b0;
    btn_sel = 1'b1; tick(2); btn_sel = 1'b0;
    btn_down = 1'b1; tick(1); btn_down = 1'b0;
    chk("disabled_valid", int'(place_valid), 0);
    chk("disabled_move_idx", int'(cursor_idx), 8);
    tick(1);

    // Reset while a request is pending and the repeat FSM is running
    enable = 1'b1;
    btn_sel = 1'b1; tick(1); btn_sel = 1'b0;
    btn_right = 1'b1; tick(13);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("rst_valid", int'(place_valid), 0);
    chk("rst_pidx", int'(place_idx), 0);
    tick(1);
    chk("rst_no_step_idx", int'(cursor_idx), 4);
    btn_right = 1'b0; tick(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        int unsigned pick;
        bit [4:0] b;
        b = cur_btn();
        pick = $urandom_range(9);
        if (pick < 4)       b[3:0] = 4'b0001 << pick;
        else if (pick < 6)  b[3:0] = 4'b0000;
        else                b[3:0] = 4'($urandom_range(15));
        set_btn(b);
      end
      if ($urandom_range(3) == 0) btn_sel = ~btn_sel;
      enable      = ($urandom_range(9) != 0);
      place_ready = ($urandom_range(3) == 0);
      rst_n       = ($urandom_range(199) != 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
